mem_stage_ctrl: RTL and testbench

- Memory (M) stage controller: consumes the E/M latch contents plus the M-stage bypass select, issues data-memory accesses through a req/ack handshake, stalls upstream while an access is outstanding, and loads the M/W pipeline register.
- Source of the `mw_instruction` compared against `em_instruction` in the memory-bypass path.
- Sits between the E/M latch and the writeback stage; the data memory is a separate block with variable latency.

---
 rtl/mem_stage_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Brief    : M-stage controller. Issues data-memory req/ack accesses for
//            lw/sw, stalls upstream while busy and loads the M/W register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
    parameter int          ADDR_W    = 12,
    parameter logic [4:0]  LW_OPCODE = 5'b01000,
    parameter logic [4:0]  SW_OPCODE = 5'b00111
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       em_instruction,
    input  logic              em_valid,
    input  logic [31:0]       em_alu_result,
    input  logic [31:0]       em_rt_data,
    input  logic              bypass_sig,
    input  logic [31:0]       mw_wb_data,
    output logic              stall_m,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic [31:0]       mw_instruction,
    output logic              mw_valid,
    output logic [31:0]       mw_o,
    output logic [31:0]       mw_d
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_complete;
    logic                w_stall;

    logic [4:0]          w_opcode;
    logic                w_is_sw;
    logic                w_memop;

    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_cap_instr;
    logic [31:0]         r_cap_alu;
    logic [31:0]         r_mw_instr;
    logic                r_mw_valid;
    logic [31:0]         r_mw_o;
    logic [31:0]         r_mw_d;

    assign w_opcode = em_instruction[31:27];
    assign w_is_sw  = (w_opcode == SW_OPCODE);
    assign w_memop  = em_valid & ((w_opcode == LW_OPCODE) | w_is_sw);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The stall is a function of state, E/M contents and ack only; rdata never feeds it.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_memop) begin
                    w_accept    = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_stall = ~dmem_ack;
                if (dmem_ack) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cap_instr <= '0;
            r_cap_alu   <= '0;
            r_mw_instr  <= '0;
            r_mw_valid  <= 1'b0;
            r_mw_o      <= '0;
            r_mw_d      <= '0;
        end else begin
            // M/W defaults to a bubble; the branches below override it.
            r_mw_instr <= '0;
            r_mw_valid <= 1'b0;
            r_mw_o     <= '0;
            r_mw_d     <= '0;
            if (w_accept) begin
                r_we        <= w_is_sw;
                r_addr      <= em_alu_result[ADDR_W-1:0];
                r_wdata     <= bypass_sig ? mw_wb_data : em_rt_data;
                r_cap_instr <= em_instruction;
                r_cap_alu   <= em_alu_result;
            end else if (w_complete) begin
                r_mw_instr <= r_cap_instr;
                r_mw_valid <= 1'b1;
                r_mw_o     <= r_cap_alu;
                r_mw_d     <= r_we ? 32'd0 : dmem_rdata;
            end else if ((r_state == S_IDLE) && em_valid) begin
                r_mw_instr <= em_instruction;
                r_mw_valid <= 1'b1;
                r_mw_o     <= em_alu_result;
            end
        end
    end

    assign stall_m        = w_stall;
    assign dmem_req       = (r_state == S_BUSY);
    assign dmem_we        = r_we;
    assign dmem_addr      = r_addr;
    assign dmem_wdata     = r_wdata;
    assign mw_instruction = r_mw_instr;
    assign mw_valid       = r_mw_valid;
    assign mw_o           = r_mw_o;
    assign mw_d           = r_mw_d;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Brief    : Directed self-checking bench for mem_stage_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_ctrl;

    localparam int          ADDR_W = 12;
    localparam logic [31:0] C_LW   = 32'h4000_0010;
    localparam logic [31:0] C_SW   = 32'h3800_0004;
    localparam logic [31:0] C_ADD  = 32'h0000_1234;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [31:0]       em_instruction;
    logic              em_valid;
    logic [31:0]       em_alu_result;
    logic [31:0]       em_rt_data;
    logic              bypass_sig;
    logic [31:0]       mw_wb_data;
    logic              stall_m;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;
    logic [31:0]       mw_instruction;
    logic              mw_valid;
    logic [31:0]       mw_o;
    logic [31:0]       mw_d;

    int checks   = 0;
    int failures = 0;

    mem_stage_ctrl #(
        .ADDR_W    (ADDR_W),
        .LW_OPCODE (5'b01000),
        .SW_OPCODE (5'b00111)
    ) u_dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .em_instruction (em_instruction),
        .em_valid       (em_valid),
        .em_alu_result  (em_alu_result),
        .em_rt_data     (em_rt_data),
        .bypass_sig     (bypass_sig),
        .mw_wb_data     (mw_wb_data),
        .stall_m        (stall_m),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .mw_instruction (mw_instruction),
        .mw_valid       (mw_valid),
        .mw_o           (mw_o),
        .mw_d           (mw_d)
    );

    always #5 clock = ~clock;

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        em_instruction = C_LW;
        em_valid       = 1'b1;
        em_alu_result  = 32'h0000_0010;
        em_rt_data     = 32'h0;
        bypass_sig     = 1'b0;
        mw_wb_data     = 32'h0;
        dmem_ack       = 1'b0;
        dmem_rdata     = 32'h0;
        cyc();
        cyc();
        reset_n  = 1'b1;
        em_valid = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 12'h0 || dmem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_dmem: req=%b we=%b addr=%h wdata=%h expected all zero",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        checks++;
        if (mw_instruction !== 32'h0 || mw_valid !== 1'b0 || mw_o !== 32'h0 || mw_d !== 32'h0) begin
            failures++;
            $display("FAIL reset_mw: instr=%h valid=%b o=%h d=%h expected all zero",
                     mw_instruction, mw_valid, mw_o, mw_d);
        end
        checks++;
        if (stall_m !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: got %b expected 0", stall_m);
        end
    endtask

    task automatic test_alu_pass();
        em_instruction = C_ADD;
        em_valid       = 1'b1;
        em_alu_result  = 32'h0000_0123;
        #1;
        checks++;
        if (stall_m !== 1'b0) begin
            failures++;
            $display("FAIL alu_stall: got %b expected 0", stall_m);
        end
        cyc();
        em_valid = 1'b0;
        #1;
        checks++;
        if (mw_valid !== 1'b1 || mw_o !== 32'h0000_0123 || mw_d !== 32'h0 || mw_instruction !== C_ADD) begin
            failures++;
            $display("FAIL alu_mw: valid=%b o=%h d=%h instr=%h expected 1 00000123 00000000 %h",
                     mw_valid, mw_o, mw_d, mw_instruction, C_ADD);
        end
        cyc();
        #1;
        checks++;
        if (mw_valid !== 1'b0 || stall_m !== 1'b0) begin
            failures++;
            $display("FAIL alu_bubble: valid=%b stall=%b expected 0 0", mw_valid, stall_m);
        end
    endtask

    task automatic test_load_delayed();
        em_instruction = C_LW;
        em_valid       = 1'b1;
        em_alu_result  = 32'h0000_0010;
        dmem_rdata     = 32'h1111_1111;
        #1;
        checks++;
        if (stall_m !== 1'b1 || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL load_accept: stall=%b req=%b expected 1 0", stall_m, dmem_req);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            #1;
            checks++;
            if (stall_m !== 1'b1 || dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 12'h010 || mw_valid !== 1'b0) begin
                failures++;
                $display("FAIL load_wait%0d: stall=%b req=%b we=%b addr=%h mwv=%b expected 1 1 0 010 0",
                         i, stall_m, dmem_req, dmem_we, dmem_addr, mw_valid);
            end
        end
        cyc();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (stall_m !== 1'b0 || dmem_req !== 1'b1 || dmem_addr !== 12'h010 || mw_valid !== 1'b0) begin
            failures++;
            $display("FAIL load_ack: stall=%b req=%b addr=%h mwv=%b expected 0 1 010 0",
                     stall_m, dmem_req, dmem_addr, mw_valid);
        end
        cyc();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h2222_2222;
        em_valid   = 1'b0;
        #1;
        checks++;
        if (mw_valid !== 1'b1 || mw_d !== 32'hDEAD_BEEF || mw_o !== 32'h0000_0010 || mw_instruction !== C_LW || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL load_mw: valid=%b d=%h o=%h instr=%h req=%b expected 1 deadbeef 00000010 %h 0",
                     mw_valid, mw_d, mw_o, mw_instruction, C_LW, dmem_req);
        end
        cyc();
    endtask

    task automatic test_store_bypass();
        em_instruction = C_SW;
        em_valid       = 1'b1;
        em_alu_result  = 32'h0000_1ABC;
        em_rt_data     = 32'h0000_00AA;
        bypass_sig     = 1'b1;
        mw_wb_data     = 32'h0000_0055;
        #1;
        checks++;
        if (stall_m !== 1'b1) begin
            failures++;
            $display("FAIL store_accept: stall=%b expected 1", stall_m);
        end
        cyc();
        mw_wb_data = 32'h0000_0077;
        #1;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h0000_0055 || dmem_addr !== 12'hABC) begin
            failures++;
            $display("FAIL store_busy: req=%b we=%b wdata=%h addr=%h expected 1 1 00000055 abc",
                     dmem_req, dmem_we, dmem_wdata, dmem_addr);
        end
        cyc();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h3333_3333;
        #1;
        checks++;
        if (dmem_we !== 1'b1 || dmem_wdata !== 32'h0000_0055 || stall_m !== 1'b0) begin
            failures++;
            $display("FAIL store_ack: we=%b wdata=%h stall=%b expected 1 00000055 0",
                     dmem_we, dmem_wdata, stall_m);
        end
        cyc();
        dmem_ack   = 1'b0;
        em_valid   = 1'b0;
        bypass_sig = 1'b0;
        #1;
        checks++;
        if (mw_valid !== 1'b1 || mw_d !== 32'h0 || mw_o !== 32'h0000_1ABC || mw_instruction !== C_SW) begin
            failures++;
            $display("FAIL store_mw: valid=%b d=%h o=%h instr=%h expected 1 00000000 00001abc %h",
                     mw_valid, mw_d, mw_o, mw_instruction, C_SW);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        em_instruction = C_LW;
        em_valid       = 1'b1;
        em_alu_result  = 32'h0000_0020;
        cyc();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if (dmem_req !== 1'b1 || stall_m !== 1'b0 || dmem_addr !== 12'h020) begin
            failures++;
            $display("FAIL b2b_lw_ack: req=%b stall=%b addr=%h expected 1 0 020", dmem_req, stall_m, dmem_addr);
        end
        cyc();
        dmem_ack       = 1'b0;
        em_instruction = C_SW;
        em_alu_result  = 32'h0000_0030;
        em_rt_data     = 32'h1111_2222;
        #1;
        checks++;
        if (mw_valid !== 1'b1 || mw_d !== 32'hCAFE_F00D || dmem_req !== 1'b0 || stall_m !== 1'b1) begin
            failures++;
            $display("FAIL b2b_lw_done: mwv=%b d=%h req=%b stall=%b expected 1 cafef00d 0 1",
                     mw_valid, mw_d, dmem_req, stall_m);
        end
        cyc();
        dmem_ack = 1'b1;
        #1;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h1111_2222 || dmem_addr !== 12'h030 || mw_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_sw_busy: req=%b we=%b wdata=%h addr=%h mwv=%b expected 1 1 11112222 030 0",
                     dmem_req, dmem_we, dmem_wdata, dmem_addr, mw_valid);
        end
        cyc();
        dmem_ack = 1'b0;
        em_valid = 1'b0;
        #1;
        checks++;
        if (mw_valid !== 1'b1 || mw_instruction !== C_SW || mw_d !== 32'h0 || mw_o !== 32'h0000_0030) begin
            failures++;
            $display("FAIL b2b_sw_done: valid=%b instr=%h d=%h o=%h expected 1 %h 00000000 00000030",
                     mw_valid, mw_instruction, mw_d, mw_o, C_SW);
        end
        cyc();
    endtask

    task automatic test_ack_idle();
        em_valid   = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h4444_4444;
        #1;
        checks++;
        if (stall_m !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack_stall: got %b expected 0", stall_m);
        end
        cyc();
        dmem_ack = 1'b0;
        #1;
        checks++;
        if (mw_valid !== 1'b0 || dmem_req !== 1'b0 || mw_d !== 32'h0) begin
            failures++;
            $display("FAIL idle_ack_mw: valid=%b req=%b d=%h expected 0 0 00000000", mw_valid, dmem_req, mw_d);
        end
    endtask

    task automatic test_reset_mid();
        em_instruction = C_LW;
        em_valid       = 1'b1;
        em_alu_result  = 32'h0000_0040;
        cyc();
        #1;
        checks++;
        if (dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL midrst_busy: req=%b expected 1", dmem_req);
        end
        reset_n  = 1'b0;
        em_valid = 1'b0;
        cyc();
        reset_n    = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_5555;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || stall_m !== 1'b0 || dmem_addr !== 12'h0) begin
            failures++;
            $display("FAIL midrst_after: req=%b stall=%b addr=%h expected 0 0 000", dmem_req, stall_m, dmem_addr);
        end
        cyc();
        dmem_ack = 1'b0;
        #1;
        checks++;
        if (mw_valid !== 1'b0 || mw_o !== 32'h0 || mw_d !== 32'h0 || mw_instruction !== 32'h0) begin
            failures++;
            $display("FAIL midrst_mw: valid=%b o=%h d=%h instr=%h expected all zero",
                     mw_valid, mw_o, mw_d, mw_instruction);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_alu_pass();
        test_load_delayed();
        test_store_bypass();
        test_back_to_back();
        test_ack_idle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
